// File: rtl/apb_master_param.sv
// APB3 bridge master: single-beat core requests to NUM_SLAVES equal power-of-two regions,
// with PSTRB, PSLVERR forwarding, unmapped-address errors, wait-state timeout and back-to-back beats.
module apb_master_param #(
    parameter int                NUM_SLAVES  = 6,
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h1000_0000,
    parameter int                REGION_BITS = 12,
    parameter int                TIMEOUT     = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    output logic [ADDR_W-1:0]            PADDR,
    output logic                         PWRITE,
    output logic                         PENABLE,
    output logic [DATA_W-1:0]            PWDATA,
    output logic [DATA_W/8-1:0]          PSTRB,
    output logic [NUM_SLAVES-1:0]        PSEL,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR,
    input  logic                         transfer,
    input  logic                         write,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W/8-1:0]          strb,
    output logic                         ready,
    output logic [DATA_W-1:0]            rdata,
    output logic                         error,
    output logic [1:0]                   dbg_state
);

    localparam int TAG_W  = ADDR_W - REGION_BITS;
    localparam int IDX_W  = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int STRB_W = DATA_W / 8;
    localparam logic [TAG_W-1:0] BASE_TAG  = BASE_ADDR[ADDR_W-1:REGION_BITS];
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, ERR} state_t;

    state_t              state, state_next;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   strb_q;
    logic                write_q;
    logic [IDX_W-1:0]    idx_q;
    logic [CNT_W-1:0]    wait_cnt;

    logic                req_hit;
    logic [IDX_W-1:0]    req_idx;
    logic                pready_s;
    logic                pslverr_s;
    logic [DATA_W-1:0]   prdata_s;
    logic                timed_out;
    logic                complete;
    logic                accept;

    // Handshake: a request is taken when transfer=1 in IDLE or in the completing ACCESS
    // cycle; its result is the one-cycle ready pulse carrying rdata and error.
    always_comb begin
        req_hit = 1'b0;
        req_idx = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (addr[ADDR_W-1:REGION_BITS] == BASE_TAG + TAG_W'(i)) begin
                req_hit = 1'b1;
                req_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        pready_s  = 1'b0;
        pslverr_s = 1'b0;
        prdata_s  = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                pready_s  = PREADY[i];
                pslverr_s = PSLVERR[i];
                prdata_s  = PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    assign timed_out = (TIMEOUT != 0) && !pready_s && (wait_cnt == CNT_LIMIT);
    assign complete  = (state == ACCESS) && (pready_s || timed_out);
    assign accept    = transfer && ((state == IDLE) || complete);

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        error      = 1'b0;
        rdata      = '0;
        case (state)
            IDLE:   if (accept) state_next = req_hit ? SETUP : ERR;
            SETUP:  state_next = ACCESS;
            ACCESS: begin
                if (complete) begin
                    ready = 1'b1;
                    if (pready_s) begin
                        error = pslverr_s;
                        rdata = prdata_s;
                    end else begin
                        error = 1'b1;
                    end
                    if (accept) state_next = req_hit ? SETUP : ERR;
                    else        state_next = IDLE;
                end
            end
            ERR: begin
                ready      = 1'b1;
                error      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state    <= IDLE;
            addr_q   <= '0;
            wdata_q  <= '0;
            strb_q   <= '0;
            write_q  <= 1'b0;
            idx_q    <= '0;
            wait_cnt <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                strb_q  <= write ? strb : '0;
                write_q <= write;
                idx_q   <= req_idx;
            end
            // Counter saturates so a disabled timeout can never wrap into a false match.
            if (state == SETUP)
                wait_cnt <= '0;
            else if ((state == ACCESS) && !pready_s && (wait_cnt != {CNT_W{1'b1}}))
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign PADDR     = addr_q;
    assign PWRITE    = write_q;
    assign PWDATA    = wdata_q;
    assign PSTRB     = strb_q;
    assign PENABLE   = (state == ACCESS);
    assign PSEL      = ((state == SETUP) || (state == ACCESS)) ? (NUM_SLAVES'(1) << idx_q) : '0;
    assign dbg_state = state;

endmodule

// File: tb/tb_apb_master_param.sv
// Self-checking bench for apb_master_param: directed APB scenarios plus a short random mix,
// with results checked against an expected {error, rdata} queue.
module tb_apb_master_param;

  localparam int NS = 6;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 4;
  localparam logic [1:0] S_IDLE = 2'd0, S_SETUP = 2'd1, S_ACCESS = 2'd2, S_ERR = 2'd3;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic [AW-1:0] PADDR;
  logic          PWRITE, PENABLE;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic [NS-1:0] PSEL;
  logic [NS*DW-1:0] prdata_bus;
  logic [NS-1:0] pready, pslverr;
  logic          transfer, write;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [SW-1:0] strb;
  logic          ready, error;
  logic [DW-1:0] rdata;
  logic [1:0]    dbg_state;

  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];
  logic [DW:0] exp_v;

  // clock / reset
  always #5 PCLK = ~PCLK;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  apb_master_param #(
    .NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW),
    .BASE_ADDR(32'h1000_0000), .REGION_BITS(12), .TIMEOUT(TO)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PSEL(PSEL), .PRDATA(prdata_bus), .PREADY(pready),
    .PSLVERR(pslverr), .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
    .strb(strb), .ready(ready), .rdata(rdata), .error(error), .dbg_state(dbg_state)
  );

  // driver tasks
  task automatic drive_idle();
    transfer = 1'b0; write = 1'b0; addr = '0; wdata = '0; strb = '0;
  endtask

  task automatic drive_req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic [SW-1:0] s);
    transfer = 1'b1; write = w; addr = a; wdata = d; strb = s;
  endtask

  task automatic test_reset();
    PRESET = 1'b1;
    drive_idle();
    pready = '1; pslverr = '0; prdata_bus = '0;
    repeat (2) @(negedge PCLK);
    #1;
    checks++;
    if ({PADDR, PWRITE, PWDATA, PSTRB, PSEL, PENABLE, ready, rdata, error} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: PADDR=%h PSEL=%b PENABLE=%b ready=%b rdata=%h error=%b, all required 0",
               PADDR, PSEL, PENABLE, ready, rdata, error);
    end
    checks++;
    if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, S_IDLE); end
    @(negedge PCLK);
    PRESET = 1'b0;
  endtask

  task automatic test_mapped_write();
    @(negedge PCLK);
    pready = '1; pslverr = 6'b000001;
    prdata_bus[1*DW +: DW] = 32'h1111_2222;
    drive_req(1'b1, 32'h1000_1004, 32'hDEAD_BEEF, 4'hF);
    exp_q.push_back({1'b0, 32'h1111_2222});
    #1;
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL wr_idle_ready: got %b exp 0", ready); end
    @(negedge PCLK);
    drive_idle();
    #1;
    checks++;
    if ({dbg_state, PSEL, PENABLE} !== {S_SETUP, 6'b000010, 1'b0}) begin
      errors++; $display("FAIL wr_setup: state=%0d PSEL=%b PENABLE=%b exp 1/000010/0", dbg_state, PSEL, PENABLE);
    end
    checks++;
    if ({PADDR, PWDATA, PSTRB, PWRITE} !== {32'h1000_1004, 32'hDEAD_BEEF, 4'hF, 1'b1}) begin
      errors++; $display("FAIL wr_latched: PADDR=%h PWDATA=%h PSTRB=%h PWRITE=%b", PADDR, PWDATA, PSTRB, PWRITE);
    end
    checks++;
    if (ready !== 1'b0) begin errors++; $display("FAIL wr_setup_ready: got %b exp 0", ready); end
    @(negedge PCLK);
    #1;
    checks++;
    if ({dbg_state, PSEL, PENABLE, ready} !== {S_ACCESS, 6'b000010, 1'b1, 1'b1}) begin
      errors++; $display("FAIL wr_access: state=%0d PSEL=%b PENABLE=%b ready=%b", dbg_state, PSEL, PENABLE, ready);
    end
    checks++;
    if (exp_q.size() == 0) begin errors++; $display("FAIL wr_sb: ready with empty expected queue"); end
    else begin
      exp_v = exp_q.pop_front();
      if ({error, rdata} !== exp_v) begin errors++; $display("FAIL wr_sb: got %h exp %h", {error, rdata}, exp_v); end
    end
    @(negedge PCLK);
    pslverr = '0;
    #1;
    checks++;
    if ({dbg_state, PSEL, ready} !== {S_IDLE, 6'b0, 1'b0}) begin
      errors++; $display("FAIL wr_back_idle: state=%0d PSEL=%b ready=%b", dbg_state, PSEL, ready);
    end
  endtask

  task automatic test_wait_read();
    @(negedge PCLK);
    pready = 6'b101111;
    prdata_bus[4*DW +: DW] = 32'h0000_0055;
    drive_req(1'b0, 32'h1000_4000, 32'h1234_5678, 4'hF);
    exp_q.push_back({1'b0, 32'h0000_0055});
    @(negedge PCLK);
    drive_idle();
    #1;
    checks++;
    if ({PSEL, PSTRB, PWRITE} !== {6'b010000, 4'h0, 1'b0}) begin
      errors++; $display("FAIL rd_setup: PSEL=%b PSTRB=%h PWRITE=%b exp 010000/0/0", PSEL, PSTRB, PWRITE);
    end
    for (int k = 1; k <= 3; k++) begin
      @(negedge PCLK);
      #1;
      checks++;
      if ({dbg_state, PENABLE, ready} !== {S_ACCESS, 1'b1, 1'b0}) begin
        errors++; $display("FAIL rd_wait%0d: state=%0d PENABLE=%b ready=%b", k, dbg_state, PENABLE, ready);
      end
    end
    @(negedge PCLK);
    pready[4] = 1'b1;
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL rd_ready: got %b exp 1", ready); end
    else if (exp_q.size() == 0) begin errors++; $display("FAIL rd_sb: empty expected queue"); end
    else begin
      exp_v = exp_q.pop_front();
      if ({error, rdata} !== exp_v) begin errors++; $display("FAIL rd_sb: got %h exp %h", {error, rdata}, exp_v); end
    end
    @(negedge PCLK);
    #1;
    checks++;
    if ({dbg_state, ready, rdata} !== {S_IDLE, 1'b0, 32'h0}) begin
      errors++; $display("FAIL rd_after: state=%0d ready=%b rdata=%h", dbg_state, ready, rdata);
    end
  endtask

  task automatic test_unmapped();
    logic [AW-1:0] bad [3];
    bad[0] = 32'h2000_0000; bad[1] = 32'h1000_6000; bad[2] = 32'h0FFF_F000;
    pready = '1; pslverr = '0;
    for (int t = 0; t < 3; t++) begin
      @(negedge PCLK);
      drive_req(1'b0, bad[t], '0, '0);
      exp_q.push_back({1'b1, 32'h0});
      @(negedge PCLK);
      addr = 32'h1000_0000;
      #1;
      checks++;
      if ({dbg_state, PSEL, ready} !== {S_ERR, 6'b0, 1'b1}) begin
        errors++; $display("FAIL unmapped%0d: state=%0d PSEL=%b ready=%b", t, dbg_state, PSEL, ready);
      end
      checks++;
      if (exp_q.size() == 0) begin errors++; $display("FAIL unmapped%0d_sb: empty expected queue", t); end
      else begin
        exp_v = exp_q.pop_front();
        if ({error, rdata} !== exp_v) begin errors++; $display("FAIL unmapped%0d_sb: got %h exp %h", t, {error, rdata}, exp_v); end
      end
      @(negedge PCLK);
      drive_idle();
      #1;
      checks++;
      if ({dbg_state, ready, PSEL} !== {S_IDLE, 1'b0, 6'b0}) begin
        errors++; $display("FAIL unmapped%0d_idle: state=%0d ready=%b PSEL=%b", t, dbg_state, ready, PSEL);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge PCLK);
    pready = '1; pslverr = '0;
    prdata_bus[0*DW +: DW] = 32'hA0A0_0000;
    prdata_bus[5*DW +: DW] = 32'h5555_AAAA;
    drive_req(1'b0, 32'h1000_0000, '0, '0);
    exp_q.push_back({1'b0, 32'hA0A0_0000});
    @(negedge PCLK);
    addr = 32'h1000_5000;
    #1;
    checks++;
    if ({dbg_state, PSEL, PADDR} !== {S_SETUP, 6'b000001, 32'h1000_0000}) begin
      errors++; $display("FAIL b2b_setup0: state=%0d PSEL=%b PADDR=%h", dbg_state, PSEL, PADDR);
    end
    @(negedge PCLK);
    exp_q.push_back({1'b0, 32'h5555_AAAA});
    #1;
    checks++;
    if ({dbg_state, ready} !== {S_ACCESS, 1'b1}) begin
      errors++; $display("FAIL b2b_access0: state=%0d ready=%b", dbg_state, ready);
    end else begin
      exp_v = exp_q.pop_front();
      if ({error, rdata} !== exp_v) begin errors++; $display("FAIL b2b_sb0: got %h exp %h", {error, rdata}, exp_v); end
    end
    @(negedge PCLK);
    drive_idle();
    #1;
    checks++;
    if ({dbg_state, PSEL, PENABLE, PADDR, ready} !== {S_SETUP, 6'b100000, 1'b0, 32'h1000_5000, 1'b0}) begin
      errors++; $display("FAIL b2b_setup5: state=%0d PSEL=%b PENABLE=%b PADDR=%h ready=%b",
                         dbg_state, PSEL, PENABLE, PADDR, ready);
    end
    @(negedge PCLK);
    #1;
    checks++;
    if ({dbg_state, ready} !== {S_ACCESS, 1'b1}) begin
      errors++; $display("FAIL b2b_access5: state=%0d ready=%b", dbg_state, ready);
    end else if (exp_q.size() == 0) begin errors++; $display("FAIL b2b_sb5: empty expected queue"); end
    else begin
      exp_v = exp_q.pop_front();
      if ({error, rdata} !== exp_v) begin errors++; $display("FAIL b2b_sb5: got %h exp %h", {error, rdata}, exp_v); end
    end
    @(negedge PCLK);
    #1;
    checks++;
    if (dbg_state !== S_IDLE) begin errors++; $display("FAIL b2b_idle: got %0d exp %0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_slave_error();
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    d = $urandom;
    s = SW'($urandom_range(1, 15));
    @(negedge PCLK);
    pready = '1; pslverr = 6'b000100;
    prdata_bus[2*DW +: DW] = 32'hC0DE_0002;
    drive_req(1'b1, 32'h1000_2010, d, s);
    exp_q.push_back({1'b1, 32'hC0DE_0002});
    @(negedge PCLK);
    drive_idle();
    #1;
    checks++;
    if ({PSEL, PSTRB, PWDATA} !== {6'b000100, s, d}) begin
      errors++; $display("FAIL slverr_setup: PSEL=%b PSTRB=%h PWDATA=%h exp 000100/%h/%h", PSEL, PSTRB, PWDATA, s, d);
    end
    @(negedge PCLK);
    #1;
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL slverr_ready: got %b exp 1", ready); end
    else if (exp_q.size() == 0) begin errors++; $display("FAIL slverr_sb: empty expected queue"); end
    else begin
      exp_v = exp_q.pop_front();
      if ({error, rdata} !== exp_v) begin errors++; $display("FAIL slverr_sb: got %h exp %h", {error, rdata}, exp_v); end
    end
    @(negedge PCLK);
    pslverr = '0;
  endtask

  task automatic test_random_mix();
    int s, w;
    logic [DW-1:0] d;
    logic e;
    for (int t = 0; t < 8; t++) begin
      s = $urandom_range(0, NS - 1);
      w = $urandom_range(0, TO - 1);
      d = $urandom;
      e = 1'($urandom_range(0, 1));
      @(negedge PCLK);
      pready = '1; pready[s] = 1'b0;
      pslverr = '0; pslverr[s] = e;
      prdata_bus[s*DW +: DW] = d;
      drive_req(1'($urandom_range(0, 1)), 32'h1000_0000 + AW'(s) * 32'h1000 + AW'($urandom_range(0, 1023) * 4),
                $urandom, SW'($urandom_range(0, 15)));
      exp_q.push_back({e, d});
      @(negedge PCLK);
      drive_idle();
      #1;
      checks++;
      if (PSEL !== (NS'(1) << s)) begin errors++; $display("FAIL mix%0d_psel: got %b exp slave %0d", t, PSEL, s); end
      for (int k = 0; k < w; k++) begin
        @(negedge PCLK);
        #1;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("FAIL mix%0d_wait%0d: ready=%b exp 0", t, k, ready); end
      end
      @(negedge PCLK);
      pready[s] = 1'b1;
      #1;
      checks++;
      if (ready !== 1'b1) begin errors++; $display("FAIL mix%0d_ready: got %b exp 1", t, ready); end
      else if (exp_q.size() == 0) begin errors++; $display("FAIL mix%0d_sb: empty expected queue", t); end
      else begin
        exp_v = exp_q.pop_front();
        if ({error, rdata} !== exp_v) begin errors++; $display("FAIL mix%0d_sb: got %h exp %h", t, {error, rdata}, exp_v); end
      end
    end
    @(negedge PCLK);
    pready = '1; pslverr = '0;
  endtask

  task automatic test_timeout();
    int n;
    logic found;
    @(negedge PCLK);
    pready = 6'b110111; pslverr = '0;
    prdata_bus[3*DW +: DW] = 32'hAAAA_5555;
    drive_req(1'b0, 32'h1000_3000, '0, '0);
    exp_q.push_back({1'b1, 32'h0});
    @(negedge PCLK);
    drive_idle();
    n = 0; found = 1'b0;
    while (!found && n < 12) begin
      @(negedge PCLK);
      #1;
      n++;
      if (ready) found = 1'b1;
    end
    checks++;
    if (!found || n != TO + 1) begin
      errors++; $display("FAIL timeout_cycle: ready seen=%b at ACCESS cycle %0d, exp cycle %0d", found, n, TO + 1);
    end
    checks++;
    if (!found) begin errors++; $display("FAIL timeout_sb: no completion observed"); end
    else if (exp_q.size() == 0) begin errors++; $display("FAIL timeout_sb: empty expected queue"); end
    else begin
      exp_v = exp_q.pop_front();
      if ({error, rdata} !== exp_v) begin errors++; $display("FAIL timeout_sb: got %h exp %h", {error, rdata}, exp_v); end
    end
    @(negedge PCLK);
    #1;
    checks++;
    if ({dbg_state, PSEL, ready} !== {S_IDLE, 6'b0, 1'b0}) begin
      errors++; $display("FAIL timeout_idle: state=%0d PSEL=%b ready=%b", dbg_state, PSEL, ready);
    end
    pready = '1;
  endtask

  task automatic test_reset_mid();
    @(negedge PCLK);
    pready = 6'b111101; pslverr = '0;
    drive_req(1'b1, 32'h1000_1000, 32'h0BAD_F00D, 4'h3);
    @(negedge PCLK);
    drive_idle();
    @(negedge PCLK);
    #1;
    checks++;
    if ({dbg_state, ready} !== {S_ACCESS, 1'b0}) begin
      errors++; $display("FAIL rstmid_access: state=%0d ready=%b", dbg_state, ready);
    end
    PRESET = 1'b1;
    @(negedge PCLK);
    #1;
    checks++;
    if ({PADDR, PWRITE, PWDATA, PSTRB, PSEL, PENABLE, ready, rdata, error} !== '0 || dbg_state !== S_IDLE) begin
      errors++; $display("FAIL rstmid_outputs: state=%0d PADDR=%h PSEL=%b PENABLE=%b ready=%b error=%b",
                         dbg_state, PADDR, PSEL, PENABLE, ready, error);
    end
    PRESET = 1'b0;
    pready = '1;
    @(negedge PCLK);
    #1;
    checks++;
    if ({dbg_state, ready} !== {S_IDLE, 1'b0}) begin
      errors++; $display("FAIL rstmid_after: state=%0d ready=%b", dbg_state, ready);
    end
  endtask

  initial begin
    test_reset();
    test_mapped_write();
    test_wait_read();
    test_unmapped();
    test_back_to_back();
    test_slave_error();
    test_random_mix();
    test_timeout();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL sb_drain: %0d expected results never produced", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_master_param.md
# apb_master_param

Parametrised APB3 bridge master that turns single-beat requests from the core-side bus into APB transfers to `NUM_SLAVES` peripherals, each mapped into an equal, power-of-two region above a common base address. It generalises the fixed six-slave master with configurable width and slave count, plus `PSTRB`, `PSLVERR` forwarding and unmapped-address error completion. It also adds a wait-state timeout and back-to-back transfers without an IDLE cycle. It sits between the CPU data-memory interface and the peripheral set (RAM, GPO, GPI, GPIO, UART, FND, ...).

## Interface
- `NUM_SLAVES`, 6: number of APB slaves, 1..16.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width, a multiple of 8.
- `BASE_ADDR`, 32'h1000_0000: start of slave 0 region.
- `REGION_BITS`, 12: log2 of the region size. Slave i owns `BASE_ADDR + i*2^REGION_BITS` through the end of that region.
- `TIMEOUT`, 16: maximum ACCESS cycles with `PREADY`=0 before a forced error completion. 0 disables the timeout.

- `PCLK` in 1: single clock, all logic on the rising edge.
- `PRESET` in 1: synchronous, active-high reset.
- `PADDR` out ADDR_W: latched request address.
- `PWRITE` out 1: latched write flag.
- `PENABLE` out 1: high in ACCESS only.
- `PWDATA` out DATA_W: latched write data.
- `PSTRB` out DATA_W/8: latched byte strobes. Forced to 0 for reads.
- `PSEL` out NUM_SLAVES: one-hot slave select.
- `PRDATA` in NUM_SLAVES*DATA_W: slave i read data in slice [i*DATA_W +: DATA_W].
- `PREADY` in NUM_SLAVES: per-slave ready.
- `PSLVERR` in NUM_SLAVES: per-slave error.
- `transfer` in 1: request strobe, sampled only when the block can accept.
- `write` in 1: request direction.
- `addr` in ADDR_W: request address.
- `wdata` in DATA_W: request write data.
- `strb` in DATA_W/8: request byte strobes.
- `ready` out 1: completion pulse.
- `rdata` out DATA_W: read data, valid when `ready`=1.
- `error` out 1: error flag, valid when `ready`=1.

## Operation
- States are IDLE, SETUP, ACCESS and ERR.
- **Accept point.** A request is accepted when `transfer`=1 in IDLE, or in the ACCESS cycle where `ready`=1. On acceptance, addr/wdata/strb/write are latched into registers. All APB outputs drive from those registers only.
- **Decode.** The latched address hits slave i when `addr[ADDR_W-1:REGION_BITS] == (BASE_ADDR>>REGION_BITS) + i`, with i < NUM_SLAVES. Anything else is unmapped.
- **IDLE.** On `transfer`, go to SETUP if the address is mapped, otherwise go to ERR.
- **SETUP.** `PSEL[i]`=1 and `PENABLE`=0. Always go to ACCESS next.
- **ACCESS.** `PSEL[i]`=1 and `PENABLE`=1.
  - If `PREADY[i]`=1: `ready`=1, `rdata`=`PRDATA` slice i, `error`=`PSLVERR[i]`.
  - If `PREADY[i]`=0 and the wait counter equals TIMEOUT (TIMEOUT≠0): `ready`=1, `error`=1, `rdata`=0. This counts as a completion.
  - On completion, go to SETUP if a new mapped request is accepted, ERR if a new unmapped request is accepted, otherwise IDLE.
- **ERR.** Lasts one cycle with `ready`=1, `error`=1, `rdata`=0 and all `PSEL`=0. Always return to IDLE; `transfer` is not sampled in ERR.
- **Wait counter.** Cleared on entering ACCESS and incremented each ACCESS cycle with `PREADY[i]`=0. It is sized to hold TIMEOUT.
- **Outside completion.** In all other states and cycles, `ready`=0, `error`=0, `rdata`=0.
- **Ignored inputs.** `PREADY` and `PSLVERR` of unselected slaves are ignored. `transfer` is ignored in SETUP, in ERR, and in ACCESS cycles that are not completing.

## Timing
- **Reset.** `PRESET`=1 at a clock edge sets state to IDLE and clears the latched registers and the wait counter.
- **Outputs during and after reset.** `PADDR`=0, `PWRITE`=0, `PWDATA`=0, `PSTRB`=0, `PSEL`=0, `PENABLE`=0, `ready`=0, `rdata`=0, `error`=0.
- **Reset mid-transfer.** The transfer is abandoned and no `ready` is issued for it.
- **Latency.** A zero-wait transfer is 3 cycles from `transfer` in IDLE to `ready`: IDLE, then SETUP, then ACCESS with `ready`.
- **Back-to-back.** The second transfer needs 2 cycles per beat, with no IDLE between.
- **Unmapped request.** `ready` arrives 1 cycle after acceptance, in ERR.
- **Timeout.** Completion occurs in ACCESS cycle TIMEOUT+1 when `PREADY` stays low.
- **Combinational paths.** `ready`, `rdata` and `error` are combinational from `PREADY`, `PRDATA` and `PSLVERR` during ACCESS. All APB outputs are combinational from state and registers only, never from request inputs.

## Test plan
- **Mapped write.** Write to 0x1000_1004 with data 0xDEADBEEF and strb 0xF, slave 1 `PREADY`=1 → `PSEL`=6'b000010, SETUP then ACCESS, `PWDATA`=0xDEADBEEF, `ready`=1 on the 3rd cycle with `error`=0.
- **Wait-state read.** Read 0x1000_4000 with slave 4 holding `PREADY`=0 for 3 ACCESS cycles and returning `PRDATA`=0x55 → `ready`=1 on the 4th ACCESS cycle, `rdata`=0x55, `PSTRB`=0.
- **Unmapped and back-to-back.** Unmapped 0x2000_0000 → no `PSEL`, `ready`=`error`=1 one cycle after acceptance. Back-to-back reads to slaves 0 and 5 with `transfer` held → ACCESS, SETUP, ACCESS, with no IDLE between.
- **Slave error.** `PSLVERR[2]`=1 during the completing ACCESS → `error`=1, `ready`=1.
- **Timeout.** TIMEOUT=4, slave 3 `PREADY` stuck at 0 → `ready`=`error`=1 on the 5th ACCESS cycle, `rdata`=0, then IDLE.
- **Reset mid-transfer.** `PRESET` asserted during ACCESS with a pending wait → next cycle all outputs 0, state IDLE, no `ready`.
